// File: rtl/trap_ctrl.sv
// Execute-stage trap sequencer: detects ECALL/EBREAK/illegal/MRET, drains memory,
// commits to the CSR file for one cycle, then redirects fetch and holds the flush.
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  input  logic [31:0]      pc_i,
  input  logic             is_ecall_i,
  input  logic             is_ebreak_i,
  input  logic             is_illegal_i,
  input  logic             is_mret_i,
  input  logic             mem_busy_i,
  input  logic [31:0]      mtvec_i,
  input  logic [31:0]      mepc_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic             trap_o,
  output logic [31:0]      trap_pc_o,
  output logic [3:0]       trap_cause_o,
  output logic             mret_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] trap_cnt_o
);

  typedef enum logic [1:0] {StIdle, StDrain, StCommit, StRedirect} state_e;

  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q;
  logic [3:0]        cause_q;
  logic              is_trap_q;
  logic [3:0]        fcnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rpc_q;

  logic              event_w;
  logic              latch_w;
  logic              first_w;
  logic [3:0]        cause_w;
  logic              is_trap_w;
  logic [31:0]       target_w;

  // Direct-mode vectoring: the low two bits of mtvec/mepc never reach fetch.
  logic unused_low_bits;
  assign unused_low_bits = ^{mtvec_i[1:0], mepc_i[1:0]};

  assign event_w   = valid_i & (is_illegal_i | is_ebreak_i | is_ecall_i | is_mret_i);
  assign is_trap_w = is_illegal_i | is_ebreak_i | is_ecall_i;

  always_comb begin
    cause_w = 4'd0;
    if (is_illegal_i)     cause_w = 4'd2;
    else if (is_ebreak_i) cause_w = 4'd3;
    else if (is_ecall_i)  cause_w = 4'd11;
  end

  assign target_w = is_trap_q ? {mtvec_i[31:2], 2'b00} : {mepc_i[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    flush_o    = 1'b0;
    trap_o     = 1'b0;
    mret_o     = 1'b0;
    redirect_o = 1'b0;
    latch_w    = 1'b0;
    first_w    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (event_w) begin
          stall_o = 1'b1;
          latch_w = 1'b1;
          state_d = mem_busy_i ? StDrain : StCommit;
        end
      end
      StDrain: begin
        stall_o = 1'b1;
        if (!mem_busy_i) state_d = StCommit;
      end
      StCommit: begin
        stall_o = 1'b1;
        trap_o  = is_trap_q;
        mret_o  = ~is_trap_q;
        state_d = StRedirect;
      end
      StRedirect: begin
        stall_o    = 1'b1;
        flush_o    = 1'b1;
        first_w    = (fcnt_q == FlushLast);
        redirect_o = first_w;
        if (fcnt_q == 4'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      cause_q   <= '0;
      is_trap_q <= 1'b0;
      fcnt_q    <= '0;
      cnt_q     <= '0;
      rpc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (latch_w) begin
        pc_q      <= pc_i;
        cause_q   <= cause_w;
        is_trap_q <= is_trap_w;
      end
      if (state_q == StCommit) begin
        fcnt_q <= FlushLast;
        if (is_trap_q) cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == StRedirect && fcnt_q != 4'd0) begin
        fcnt_q <= fcnt_q - 4'd1;
      end
      if (first_w) rpc_q <= target_w;
    end
  end

  assign trap_pc_o     = pc_q;
  assign trap_cause_o  = cause_q;
  assign trap_cnt_o    = cnt_q;
  // Target is visible alongside the redirect strobe, then held.
  assign redirect_pc_o = first_w ? target_w : rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: randomized events against a timeline model.
module tb_trap_ctrl;

  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_i, is_ecall_i, is_ebreak_i, is_illegal_i, is_mret_i, mem_busy_i;
  logic [31:0] pc_i, mtvec_i, mepc_i;

  logic        stall_o, flush_o, trap_o, mret_o, redirect_o;
  logic [31:0] trap_pc_o, redirect_pc_o;
  logic [3:0]  trap_cause_o;
  logic [15:0] trap_cnt_o;

  logic        stall2, flush2, trap2, mret2, redirect2;
  logic [31:0] trap_pc2, redirect_pc2;
  logic [3:0]  cause2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(F), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .pc_i(pc_i), .is_ecall_i(is_ecall_i),
    .is_ebreak_i(is_ebreak_i), .is_illegal_i(is_illegal_i), .is_mret_i(is_mret_i),
    .mem_busy_i(mem_busy_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .stall_o(stall_o),
    .flush_o(flush_o), .trap_o(trap_o), .trap_pc_o(trap_pc_o), .trap_cause_o(trap_cause_o),
    .mret_o(mret_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .trap_cnt_o(trap_cnt_o)
  );

  trap_ctrl #(.FLUSH_CYCLES(F), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .pc_i(pc_i), .is_ecall_i(is_ecall_i),
    .is_ebreak_i(is_ebreak_i), .is_illegal_i(is_illegal_i), .is_mret_i(is_mret_i),
    .mem_busy_i(mem_busy_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .stall_o(stall2),
    .flush_o(flush2), .trap_o(trap2), .trap_pc_o(trap_pc2), .trap_cause_o(cause2),
    .mret_o(mret2), .redirect_o(redirect2), .redirect_pc_o(redirect_pc2),
    .trap_cnt_o(cnt2)
  );

  task automatic clear_inputs();
    valid_i = 1'b0; is_ecall_i = 1'b0; is_ebreak_i = 1'b0; is_illegal_i = 1'b0;
    is_mret_i = 1'b0; mem_busy_i = 1'b0; pc_i = '0; mtvec_i = '0; mepc_i = '0;
  endtask

  // Random flags while the pipeline is stalled; the DUT must ignore them.
  task automatic junk_flags();
    valid_i = 1'($urandom); is_ecall_i = 1'($urandom); is_ebreak_i = 1'($urandom);
    is_illegal_i = 1'($urandom); is_mret_i = 1'($urandom);
  endtask

  task automatic check_all_zero(input string name);
    logic [103:0] got1, got2;
    got1 = {stall_o, flush_o, trap_o, mret_o, redirect_o, trap_pc_o, trap_cause_o,
            redirect_pc_o, trap_cnt_o, 3'b0};
    got2 = {stall2, flush2, trap2, mret2, redirect2, trap_pc2, cause2, redirect_pc2,
            cnt2, 17'b0};
    checks++;
    if (got1 !== '0) begin
      errors++; $display("FAIL %s dut outputs got %h exp 0", name, got1);
    end
    checks++;
    if (got2 !== '0) begin
      errors++; $display("FAIL %s dut2 outputs got %h exp 0", name, got2);
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn = 1'b0;
    #1;
    check_all_zero("reset_values");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_cnt = 0;
  endtask

  // Runs one accepted event starting in the current (IDLE) cycle; returns in the
  // IDLE cycle right after the flush window. f = {illegal, ebreak, ecall, mret}.
  task automatic run_event(input logic [3:0] f, input logic [31:0] pc, input logic [31:0] mtvec,
                           input logic [31:0] mepc, input int busy);
    bit          is_trap;
    logic [3:0]  cause;
    logic [31:0] tgt;
    is_trap = f[3] | f[2] | f[1];
    cause   = f[3] ? 4'd2 : f[2] ? 4'd3 : f[1] ? 4'd11 : 4'd0;
    tgt     = is_trap ? (mtvec & 32'hFFFF_FFFC) : (mepc & 32'hFFFF_FFFC);

    valid_i = 1'b1;
    {is_illegal_i, is_ebreak_i, is_ecall_i, is_mret_i} = f;
    pc_i = pc; mem_busy_i = (busy > 0); mtvec_i = $urandom; mepc_i = $urandom;
    @(negedge clk);
    checks++;
    if ({stall_o, trap_o, mret_o, flush_o, redirect_o} !== 5'b10000) begin
      errors++; $display("FAIL detect got %b exp 10000",
                         {stall_o, trap_o, mret_o, flush_o, redirect_o});
    end
    @(posedge clk); #1;

    for (int c = 1; c <= busy; c++) begin
      junk_flags(); pc_i = $urandom; mem_busy_i = (c < busy);
      @(negedge clk);
      checks++;
      if ({stall_o, trap_o, mret_o, flush_o, redirect_o} !== 5'b10000) begin
        errors++; $display("FAIL drain cycle %0d got %b exp 10000", c,
                           {stall_o, trap_o, mret_o, flush_o, redirect_o});
      end
      @(posedge clk); #1;
    end

    junk_flags(); mem_busy_i = 1'($urandom);
    @(negedge clk);
    checks++;
    if ({stall_o, trap_o, mret_o, flush_o, redirect_o} !== {1'b1, is_trap, !is_trap, 2'b00}) begin
      errors++; $display("FAIL commit got %b exp %b", {stall_o, trap_o, mret_o, flush_o, redirect_o},
                         {1'b1, is_trap, !is_trap, 2'b00});
    end
    if (is_trap) begin
      checks++;
      if (trap_pc_o !== pc || trap_cause_o !== cause) begin
        errors++; $display("FAIL commit_pc_cause got %h/%0d exp %h/%0d",
                           trap_pc_o, trap_cause_o, pc, cause);
      end
    end
    @(posedge clk); #1;
    if (is_trap) model_cnt++;

    for (int i = 0; i < F; i++) begin
      junk_flags(); mem_busy_i = 1'($urandom);
      if (i == 0) begin
        mtvec_i = mtvec; mepc_i = mepc;
      end else begin
        mtvec_i = $urandom; mepc_i = $urandom;
      end
      @(negedge clk);
      checks++;
      if ({stall_o, flush_o, trap_o, mret_o, redirect_o} !== {2'b11, 2'b00, i == 0}) begin
        errors++; $display("FAIL redirect cycle %0d got %b exp %b", i,
                           {stall_o, flush_o, trap_o, mret_o, redirect_o}, {4'b1100, i == 0});
      end
      checks++;
      if (redirect_pc_o !== tgt) begin
        errors++; $display("FAIL redirect_pc got %h exp %h", redirect_pc_o, tgt);
      end
      checks++;
      if (trap_cnt_o !== 16'(model_cnt) || cnt2 !== 2'(model_cnt)) begin
        errors++; $display("FAIL trap_cnt got %0d/%0d exp %0d/%0d", trap_cnt_o, cnt2,
                           16'(model_cnt), 2'(model_cnt));
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      junk_flags(); valid_i = 1'b0; mem_busy_i = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({stall_o, flush_o, trap_o, mret_o, redirect_o} !== 5'b0) begin
        errors++; $display("FAIL %s got %b exp 00000", name,
                           {stall_o, flush_o, trap_o, mret_o, redirect_o});
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    idle_cycles(2, "idle_after_reset");
  endtask

  task automatic test_ecall();
    run_event(4'b0010, 32'h0000_0100, 32'hFFFF_FF00, 32'h0, 0);
    idle_cycles(1, "idle_after_ecall");
  endtask

  task automatic test_ebreak_drain();
    run_event(4'b0100, 32'h0000_0200, 32'h8000_0000, 32'h0, 3);
  endtask

  task automatic test_mret();
    run_event(4'b0001, 32'h0000_0300, 32'h8000_0000, 32'h0000_0104, 0);
  endtask

  task automatic test_priority();
    run_event(4'b1110, 32'h0000_0400, 32'h1234_5678, 32'h0, 1);
    run_event(4'b0011, 32'h0000_0404, 32'h1234_5678, 32'h0, 0);
    idle_cycles(4, "flags_without_valid");
  endtask

  task automatic test_wrap_misalign();
    apply_reset();
    for (int k = 0; k < 4; k++) run_event(4'b0010, $urandom, 32'hFFFF_FF01, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) run_event(4'b1000 >> k, $urandom, $urandom, $urandom, k);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [3:0] f;
      f = 4'($urandom_range(1, 15));
      run_event(f, $urandom, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2), "random_idle");
    end
  endtask

  task automatic test_reset_drain();
    valid_i = 1'b1; is_ebreak_i = 1'b1; pc_i = 32'h0000_0500; mem_busy_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; is_ebreak_i = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL drain_stall got %b exp 1", stall_o);
    end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check_all_zero("reset_in_drain");
    model_cnt = 0;
    @(negedge clk);
    rstn = 1'b1; mem_busy_i = 1'b0;
    @(posedge clk); #1;
    idle_cycles(6, "no_commit_after_reset");
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    test_reset();
    test_ecall();
    test_ebreak_drain();
    test_mret();
    test_priority();
    test_wrap_misalign();
    test_back_to_back();
    test_random();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
